sha256_padder: RTL

//  Upstream message stage for the SHA-256 engine: accepts a byte-granular message word stream,

---
 rtl/sha256_padder_pkg.sv | 13 +
 rtl/sha256_padder_if.sv | 29 ++
 rtl/sha256_padder_pad_word.sv | 23 ++
 rtl/sha256_padder.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/sha256_padder_pkg.sv
// Shared constants and state encoding for the SHA-256 message padder.
package sha256_pkg;

    localparam int BlockWidth = 512;
    localparam int LenWidth   = 64;

    typedef enum logic [1:0] {
        FILL = 2'd0,
        PAD  = 2'd1,
        EMIT = 2'd2
    } pad_state_e;

endpackage

// File: rtl/sha256_padder_if.sv
// Word-in / block-out handshake bundle between a message source, the padder and the hash core.
interface sha256_padder_if #(
    parameter int DataWidth = 32
);
    localparam int DataBytes = DataWidth >> 3;
    localparam int BytesW    = $clog2(DataBytes + 1);

    logic [DataWidth-1:0] in_data_i;
    logic [BytesW-1:0]    in_bytes_i;
    logic                 in_last_i;
    logic                 in_valid_i;
    logic                 in_ready_o;
    logic [511:0]         block_o;
    logic                 block_first_o;
    logic                 block_last_o;
    logic                 block_valid_o;
    logic                 block_ready_i;

    // slave is the padder itself; master is whatever feeds words and takes blocks
    modport slave (
        input  in_data_i, in_bytes_i, in_last_i, in_valid_i, block_ready_i,
        output in_ready_o, block_o, block_first_o, block_last_o, block_valid_o
    );

    modport master (
        output in_data_i, in_bytes_i, in_last_i, in_valid_i, block_ready_i,
        input  in_ready_o, block_o, block_first_o, block_last_o, block_valid_o
    );
endinterface

// File: rtl/sha256_padder_pad_word.sv
// Keeps the first 'bytes' bytes of an input word, zeroes the rest and drops 0x80 right after the data.
module sha256_pad_word #(
    parameter  int DataWidth = 32,
    localparam int DataBytes = DataWidth >> 3,
    localparam int BytesW    = $clog2(DataBytes + 1)
) (
    input  logic [DataWidth-1:0] data,
    input  logic [BytesW-1:0]    bytes,
    output logic [DataWidth-1:0] word
);

    always_comb begin
        word = '0;
        for (int i = 0; i < DataBytes; i++) begin
            if (i < int'(bytes)) begin
                word[DataWidth-1-8*i -: 8] = data[DataWidth-1-8*i -: 8];
            end else if (i == int'(bytes)) begin
                word[DataWidth-1-8*i -: 8] = 8'h80;
            end
        end
    end

endmodule

// File: rtl/sha256_padder.sv
// FIPS 180-4 message padder: packs words into 512-bit blocks, appends 0x80, zeros and bit length.
// Optional SHA256_PADDER_ABORT_EN adds abort_i, which drops the message in flight.
//
// state | meaning
// FILL  | accepting message words into the block buffer
// PAD   | writing 0x80 / zeros / length words, no input accepted
// EMIT  | block_valid_o high, waiting for block_ready_i
module sha256_padder
    import sha256_pkg::*;
#(
    parameter int DataWidth = 32
) (
    input logic clk_i,
    input logic rst_i,
`ifdef SHA256_PADDER_ABORT_EN
    input logic abort_i,
`endif
    sha256_padder_if.slave bus
);

    localparam int DataBytes = DataWidth >> 3;
    localparam int BytesW    = $clog2(DataBytes + 1);
    localparam int W         = BlockWidth / DataWidth;
    localparam int L         = LenWidth / DataWidth;
    localparam int LenWord   = W - L;
    localparam int CntW      = $clog2(W);

    localparam logic [CntW-1:0]   LastIdx  = CntW'(W - 1);
    localparam logic [CntW-1:0]   LenIdx   = CntW'(LenWord);
    localparam logic [BytesW-1:0] FullBeat = BytesW'(DataBytes);

    pad_state_e            state;
    logic [CntW-1:0]       word_cnt;
    logic [LenWidth-1:0]   msg_len;
    logic                  first_flag;
    logic                  pad_done;
    logic                  len_ok;
    logic                  msg_ended;
    logic [DataWidth-1:0]  buf_q [W];
    logic [DataWidth-1:0]  fill_word;
    logic [DataWidth-1:0]  len_word;
    logic                  part_beat;

    localparam logic [DataWidth-1:0] PadWord = {8'h80, {(DataWidth-8){1'b0}}};

    sha256_pad_word #(.DataWidth(DataWidth)) u_pad_word (
        .data  (bus.in_data_i),
        .bytes (bus.in_bytes_i),
        .word  (fill_word)
    );

    assign part_beat = bus.in_bytes_i < FullBeat;

    // length words are the tail of the block, most significant slice first
    always_comb begin
        len_word = '0;
        if (word_cnt >= LenIdx) begin
            len_word = DataWidth'(msg_len >> (DataWidth * (W - 1 - int'(word_cnt))));
        end
    end

    always_comb begin
        bus.block_o = '0;
        for (int i = 0; i < W; i++) begin
            bus.block_o[BlockWidth-1-DataWidth*i -: DataWidth] = buf_q[i];
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state             <= FILL;
            word_cnt          <= '0;
            msg_len           <= '0;
            first_flag        <= 1'b1;
            pad_done          <= 1'b0;
            len_ok            <= 1'b0;
            msg_ended         <= 1'b0;
            buf_q             <= '{default: '0};
            bus.in_ready_o    <= 1'b0;
            bus.block_valid_o <= 1'b0;
            bus.block_first_o <= 1'b0;
            bus.block_last_o  <= 1'b0;
`ifdef SHA256_PADDER_ABORT_EN
        end else if (abort_i) begin
            state             <= FILL;
            word_cnt          <= '0;
            msg_len           <= '0;
            first_flag        <= 1'b1;
            pad_done          <= 1'b0;
            len_ok            <= 1'b0;
            msg_ended         <= 1'b0;
            buf_q             <= '{default: '0};
            bus.in_ready_o    <= 1'b1;
            bus.block_valid_o <= 1'b0;
            bus.block_first_o <= 1'b0;
            bus.block_last_o  <= 1'b0;
`endif
        end else begin
            case (state)
                FILL: begin
                    // ready comes up one cycle after reset, then tracks the state
                    if (!bus.in_ready_o) begin
                        bus.in_ready_o <= 1'b1;
                    end else if (bus.in_valid_i) begin
                        buf_q[word_cnt] <= fill_word;
                        msg_len         <= msg_len + LenWidth'({bus.in_bytes_i, 3'b000});
                        word_cnt        <= word_cnt + 1'b1;
                        if (part_beat) begin
                            pad_done <= 1'b1;
                            len_ok   <= word_cnt < LenIdx;
                        end
                        if (bus.in_last_i) begin
                            msg_ended <= 1'b1;
                        end
                        if (word_cnt == LastIdx) begin
                            state             <= EMIT;
                            bus.in_ready_o    <= 1'b0;
                            bus.block_valid_o <= 1'b1;
                            bus.block_first_o <= first_flag;
                            bus.block_last_o  <= 1'b0;
                        end else if (bus.in_last_i) begin
                            state          <= PAD;
                            bus.in_ready_o <= 1'b0;
                        end
                    end
                end

                PAD: begin
                    word_cnt <= word_cnt + 1'b1;
                    if (!pad_done) begin
                        buf_q[word_cnt] <= PadWord;
                        pad_done        <= 1'b1;
                        len_ok          <= word_cnt < LenIdx;
                    end else if (word_cnt >= LenIdx && len_ok) begin
                        buf_q[word_cnt] <= len_word;
                    end else begin
                        buf_q[word_cnt] <= '0;
                    end
                    if (word_cnt == LastIdx) begin
                        state             <= EMIT;
                        bus.block_valid_o <= 1'b1;
                        bus.block_first_o <= first_flag;
                        bus.block_last_o  <= pad_done && len_ok;
                    end
                end

                EMIT: begin
                    if (bus.block_ready_i) begin
                        bus.block_valid_o <= 1'b0;
                        bus.block_first_o <= 1'b0;
                        bus.block_last_o  <= 1'b0;
                        first_flag        <= bus.block_last_o;
                        word_cnt          <= '0;
                        buf_q             <= '{default: '0};
                        if (bus.block_last_o) begin
                            state          <= FILL;
                            bus.in_ready_o <= 1'b1;
                            msg_len        <= '0;
                            pad_done       <= 1'b0;
                            len_ok         <= 1'b0;
                            msg_ended      <= 1'b0;
                        end else if (msg_ended) begin
                            // second block of a message: length always fits here
                            state  <= PAD;
                            len_ok <= 1'b1;
                        end else begin
                            state          <= FILL;
                            bus.in_ready_o <= 1'b1;
                        end
                    end
                end

                default: state <= FILL;
            endcase
        end
    end

endmodule
